// File: rtl/mac_fp52_seq.sv
// Sequencer that streams element triples into an fp(2,5) multiply-add pipeline and accumulates its results.
// Define MAC_FP52_SEQ_SAT_EN for saturating accumulation; otherwise the accumulator wraps.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing elements to the datapath
// DRAIN | all elements issued, waiting for in-flight results
// DONE  | result presented on out_acc until out_ready
module mac_fp52_seq #(
  parameter int LAT   = 3,
  parameter int LEN_W = 8,
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_W-1:0]        cfg_len,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [5:0]              in_a_dat,
  input  logic [5:0]              in_b_dat,
  input  logic [5:0]              in_c_dat,
  input  logic [2:0]              in_a_exp,
  input  logic [2:0]              in_b_exp,
  input  logic [2:0]              in_c_exp,
  output logic [5:0]              dp_a_dat,
  output logic [5:0]              dp_b_dat,
  output logic [5:0]              dp_c_dat,
  output logic [2:0]              dp_a_exp,
  output logic [2:0]              dp_b_exp,
  output logic [2:0]              dp_c_exp,
  input  logic signed [17:0]      dp_res,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        issue_cnt;
  logic [LAT-1:0]          vld_sr;
  logic [LAT:0]            vld_shift;
  logic                    xfer;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] res_ext;

  assign dp_a_dat = in_a_dat;
  assign dp_b_dat = in_b_dat;
  assign dp_c_dat = in_c_dat;
  assign dp_a_exp = in_a_exp;
  assign dp_b_exp = in_b_exp;
  assign dp_c_exp = in_c_exp;

  assign xfer      = in_valid & in_ready;
  assign vld_shift = {vld_sr, xfer};
  assign res_ext   = ACC_W'(dp_res);
  assign out_acc   = acc;

`ifdef MAC_FP52_SEQ_SAT_EN
  logic [ACC_W:0] sum_wide;
  assign sum_wide = {acc[ACC_W-1], acc} + {res_ext[ACC_W-1], res_ext};

  // Overflow shows up as disagreement between the guard bit and the sign bit.
  always_comb begin
    acc_sum = sum_wide[ACC_W-1:0];
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1])
      acc_sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  assign acc_sum = acc + res_ext;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (cfg_len == '0) ? DONE : RUN;
      RUN:     if (xfer && (issue_cnt + LEN_W'(1)) == len_q) state_nxt = DRAIN;
      DRAIN:   if (vld_sr == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      len_q     <= '0;
      issue_cnt <= '0;
      vld_sr    <= '0;
      acc       <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      in_ready  <= (state_nxt == RUN);
      out_valid <= (state_nxt == DONE);
      vld_sr    <= vld_shift[LAT-1:0];
      if (state == IDLE && start) begin
        len_q     <= cfg_len;
        issue_cnt <= '0;
        acc       <= '0;
      end else begin
        if (xfer)
          issue_cnt <= issue_cnt + LEN_W'(1);
        if (vld_sr[LAT-1])
          acc <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_mac_fp52_seq.sv
// Self-checking bench for mac_fp52_seq: a stub datapath returns queued results LAT cycles after issue,
// and the expected dot product is the plain sum of those results (wrapped or clamped).
module tb_mac_fp52_seq;
  localparam int LAT   = 3;
  localparam int LEN_W = 8;
  localparam int ACC_W = 24;

  typedef logic [17:0] res_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] cfg_len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_a_dat, in_b_dat, in_c_dat;
  logic [2:0]       in_a_exp, in_b_exp, in_c_exp;
  logic [5:0]       dp_a_dat, dp_b_dat, dp_c_dat;
  logic [2:0]       dp_a_exp, dp_b_exp, dp_c_exp;
  logic [17:0]      dp_res;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;

  int total = 0;
  int bad   = 0;

  res_t res_q[$];
  res_t pipe[LAT];
  int   xfer_cnt = 0;

  always #5 clk = ~clk;

  mac_fp52_seq #(.LAT(LAT), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a_dat(in_a_dat), .in_b_dat(in_b_dat), .in_c_dat(in_c_dat),
    .in_a_exp(in_a_exp), .in_b_exp(in_b_exp), .in_c_exp(in_c_exp),
    .dp_a_dat(dp_a_dat), .dp_b_dat(dp_b_dat), .dp_c_dat(dp_c_dat),
    .dp_a_exp(dp_a_exp), .dp_b_exp(dp_b_exp), .dp_c_exp(dp_c_exp),
    .dp_res(dp_res), .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc)
  );

  // Stub datapath: a transferred element's result appears LAT cycles later; otherwise junk.
  always @(posedge clk) begin
    if (in_valid && in_ready) begin
      pipe[0]  <= res_q.pop_front();
      xfer_cnt <= xfer_cnt + 1;
    end else begin
      pipe[0] <= 18'($urandom);
    end
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_res = pipe[LAT-1];

  function automatic logic [ACC_W-1:0] model(input res_t v[$]);
    longint s, mx, mn;
    s  = 0;
    mx = (longint'(1) << (ACC_W-1)) - 1;
    mn = -mx - 1;
    foreach (v[i]) begin
      s += longint'($signed(v[i]));
`ifdef MAC_FP52_SEQ_SAT_EN
      if (s > mx) s = mx;
      if (s < mn) s = mn;
`endif
    end
    return ACC_W'(s);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_elem(input int vmode, input int lat);
    case (vmode)
      0:       in_valid = 1'b1;
      1:       in_valid = (lat % 2 == 0);
      default: in_valid = 1'($urandom);
    endcase
    {in_a_dat, in_b_dat, in_c_dat} = 18'($urandom);
    {in_a_exp, in_b_exp, in_c_exp} = 9'($urandom);
  endtask

  // res_q must already hold exactly len results for this job.
  task automatic run_job(input string tag, input int len, input int vmode, input int hold, input bit poke);
    int               lat, base;
    logic [ACC_W-1:0] exp_acc, held;
    bit               stable;
    exp_acc = model(res_q);
    base    = xfer_cnt;
    cfg_len = LEN_W'(len);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (!out_valid && lat < 5000) begin
      drive_elem(vmode, lat);
      start = poke && (lat == 2);
      if (start) cfg_len = '0;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk({tag, "_done_seen"}, 64'(lat < 5000), 64'd1);
    if (len == 0) chk({tag, "_latency"}, 64'(lat), 64'd0);
    else          chk({tag, "_latency_min"}, 64'(lat >= len + LAT + 1), 64'd1);
    chk({tag, "_acc"}, 64'(out_acc), 64'(exp_acc));
    chk({tag, "_xfers"}, 64'(xfer_cnt - base), 64'(len));
    held   = out_acc;
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (out_acc !== held || out_valid !== 1'b1) stable = 1'b0;
    end
    if (hold > 0) chk({tag, "_hold_stable"}, 64'(stable), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_after"}, 64'({busy, in_ready, out_valid}), 64'd0);
  endtask

  initial begin
    int len;
    rst_n     = 1'b1;
    start     = 1'b0;
    cfg_len   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    {in_a_dat, in_b_dat, in_c_dat, in_a_exp, in_b_exp, in_c_exp} = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_flags", 64'({busy, in_ready, out_valid}), 64'd0);
    chk("reset_acc", 64'(out_acc), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_flags", 64'({busy, in_ready, out_valid}), 64'd0);

    {in_a_dat, in_b_dat, in_c_dat} = 18'($urandom);
    {in_a_exp, in_b_exp, in_c_exp} = 9'($urandom);
    #1;
    chk("dp_passthru", 64'({dp_a_dat, dp_b_dat, dp_c_dat, dp_a_exp, dp_b_exp, dp_c_exp}),
        64'({in_a_dat, in_b_dat, in_c_dat, in_a_exp, in_b_exp, in_c_exp}));
    @(negedge clk);

    repeat (4) res_q.push_back(18'h00010);
    run_job("basic", 4, 0, 0, 1'b0);

    res_q.push_back(18'h00005);
    res_q.push_back(18'h3FFF8);
    res_q.push_back(18'h00001);
    run_job("sign", 3, 0, 0, 1'b0);

    repeat (5) res_q.push_back(18'($urandom));
    run_job("handshake", 5, 1, 10, 1'b0);

    run_job("len0", 0, 0, 2, 1'b0);

    repeat (6) res_q.push_back(18'($urandom));
    run_job("start_in_run", 6, 0, 0, 1'b1);

    repeat (255) res_q.push_back(18'h1FFFF);
    run_job("sat", 255, 0, 0, 1'b0);

    // Reset with two elements in flight.
    repeat (4) res_q.push_back(18'h00123);
    cfg_len = 8'd4;
    start   = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midjob_reset_flags", 64'({busy, in_ready, out_valid}), 64'd0);
    chk("midjob_reset_acc", 64'(out_acc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    res_q.delete();
    repeat (LAT + 1) @(negedge clk);
    chk("midjob_release_flags", 64'({busy, in_ready, out_valid}), 64'd0);
    res_q.push_back(18'h2ABCD);
    run_job("after_reset", 1, 0, 0, 1'b0);

    for (int j = 0; j < 4; j++) begin
      len = $urandom_range(1, 20);
      repeat (len) res_q.push_back(18'($urandom));
      run_job($sformatf("rand%0d", j), len, 2, $urandom_range(0, 3), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mac_fp52_seq.md
MAC_FP52_SEQ -- requirements
Module: mac_fp52_seq

Interface
REQ-001 Parameter LAT, default 3: fixed issue-to-result latency of the attached fp(2,5) multiply-add pipeline, in clk cycles.
REQ-002 Parameter LEN_W, default 8: width of the vector-length field.
REQ-003 Parameter ACC_W, default 24: width of the signed accumulator; ACC_W >= 18.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 start  in  1  begin a dot-product job; sampled only in IDLE.
REQ-007 cfg_len  in  LEN_W  element count of the job; captured on an accepted start.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 in_valid, in_ready  in/out  1 each  element handshake; transfer when both are high.
REQ-010 in_a_dat, in_b_dat, in_c_dat  in  6 each  element operands.
REQ-011 in_a_exp, in_b_exp, in_c_exp  in  3 each  element exponents.
REQ-012 dp_a_dat … dp_c_exp  out  6/3  operands driven to the datapath, mirroring the in_* widths.
REQ-013 dp_res  in  18  signed datapath result, valid LAT cycles after issue.
REQ-014 out_valid, out_ready  out/in  1 each  result handshake.
REQ-015 out_acc  out  ACC_W  signed dot-product result.

Function
REQ-016 FSM states are IDLE, RUN, DRAIN and DONE.
REQ-017 IDLE->RUN on start when cfg_len != 0: latch cfg_len, clear the issue counter, clear the accumulator.
REQ-018 IDLE->DONE on start when cfg_len == 0, with out_acc = 0.
REQ-019 in_ready = 1 only in RUN; each transfer issues one element and increments the issue counter.
REQ-020 dp_* outputs are combinational from in_*; the datapath receives an element only in the cycle it transfers.
REQ-021 RUN->DRAIN in the cycle the transfer brings the issue count equal to the latched length.
REQ-022 A LAT-deep valid shift register tracks in-flight elements: bit 0 is set by a transfer, and the last bit marks dp_res as valid.
REQ-023 Each valid dp_res is sign-extended to ACC_W and added to the accumulator in the same cycle.
REQ-024 DRAIN->DONE when the shift register is all-zero and the final addition has been written.
REQ-025 out_valid = 1 only in DONE; out_acc holds the accumulator and is stable while out_valid = 1.
REQ-026 DONE->IDLE on out_ready; the next start is accepted no earlier than the following cycle.
REQ-027 start is ignored outside IDLE.
REQ-028 in_valid gaps in RUN stall issue without error; in-flight results still accumulate.
REQ-029 The total job length is cfg_len + LAT + 1 cycles minimum, from start to out_valid.

Reset
REQ-030 While rst_n = 0: state = IDLE, counters = 0, shift register = 0, accumulator = 0, busy = 0, in_ready = 0, out_valid = 0, out_acc = 0.
REQ-031 Reset mid-job discards all in-flight results; after release the block is in IDLE with no residual accumulation.

Configuration
REQ-032 Macro MAC_FP52_SEQ_SAT_EN defined: accumulation saturates to the signed ACC_W range (max 2^(ACC_W-1)-1, min -2^(ACC_W-1)).
REQ-033 Macro MAC_FP52_SEQ_SAT_EN undefined: accumulation wraps modulo 2^ACC_W.

Verification
REQ-034 Basic: cfg_len = 4, continuous in_valid, dp_res stubbed to 18'h00010 with LAT delay -> out_acc = 24'h000040, out_valid first asserted at least 8 cycles after start.
REQ-035 Sign: cfg_len = 3, dp_res sequence 5, -8, 1 -> out_acc = 24'hFFFFFE.
REQ-036 Saturation: cfg_len = 255, dp_res = 18'h1FFFF every element -> 24'h7FFFFF with MAC_FP52_SEQ_SAT_EN, 24'hFDFF01 without it.
REQ-037 Handshake: cfg_len = 5, in_valid toggling every cycle and out_ready held low for 10 cycles in DONE -> exactly 5 transfers, out_acc stable throughout, IDLE one cycle after out_ready.
REQ-038 Boundary: cfg_len = 0 -> out_valid the cycle after start, out_acc = 0, no transfers; start pulsed during RUN -> ignored.
REQ-039 Reset: rst_n asserted with 2 elements in flight, then released -> IDLE, all outputs 0, and a subsequent cfg_len = 1 job returns only that element's result.
